// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for three producers (ALU, FPU, MEM) feeding a
// shared int/float register-file write port, plus a 64-entry busy scoreboard.
module regfile_wb_arbiter #(
  parameter int unsigned PRIO_RESET = 0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [2:0]  wb_valid,
  output logic [2:0]  wb_ready,
  input  logic [2:0]  wb_fmode,
  input  logic [14:0] wb_reg,
  input  logic [95:0] wb_data,
  output logic        wenable,
  output logic        wfmode,
  output logic [4:0]  wreg,
  output logic [31:0] wdata,
  input  logic        issue_valid,
  input  logic        issue_fmode,
  input  logic [4:0]  issue_reg,
  output logic        issue_stall,
  input  logic        rfmode1,
  input  logic        rfmode2,
  input  logic [4:0]  rreg1,
  input  logic [4:0]  rreg2,
  output logic        busy1,
  output logic        busy2
);

  localparam int unsigned RW  = 5;
  localparam int unsigned DW  = 32;
  localparam int unsigned SBW = 64;
  // Pointer starts one behind the reset-priority requester so it is searched first.
  localparam logic [1:0] LAST_RST = 2'((PRIO_RESET + 32'd2) % 32'd3);

  logic [1:0]     last_grant_q, last_grant_d;
  logic           wenable_q, wenable_d;
  logic           wfmode_q, wfmode_d;
  logic [RW-1:0]  wreg_q, wreg_d;
  logic [DW-1:0]  wdata_q, wdata_d;
  logic [SBW-1:0] sb_q, sb_d;

  logic [1:0]    c0, c1, c2;
  logic [1:0]    gnt_idx;
  logic [2:0]    gnt_oh;
  logic          hs;
  logic          sel_fm;
  logic [RW-1:0] sel_reg;
  logic [DW-1:0] sel_data;
  logic          issue_x0;
  logic          issue_acc;

  function automatic logic [1:0] rr_next(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // Round-robin search starting after the last granted requester.
  always_comb begin
    c0      = rr_next(last_grant_q);
    c1      = rr_next(c0);
    c2      = rr_next(c1);
    gnt_idx = 2'd0;
    gnt_oh  = 3'b000;
    hs      = 1'b0;
    if (wb_valid[c0]) begin
      gnt_idx = c0;
      hs      = 1'b1;
    end else if (wb_valid[c1]) begin
      gnt_idx = c1;
      hs      = 1'b1;
    end else if (wb_valid[c2]) begin
      gnt_idx = c2;
      hs      = 1'b1;
    end
    if (hs) begin
      gnt_oh[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    sel_fm   = wb_fmode[0];
    sel_reg  = wb_reg[4:0];
    sel_data = wb_data[31:0];
    case (gnt_idx)
      2'd1: begin
        sel_fm   = wb_fmode[1];
        sel_reg  = wb_reg[9:5];
        sel_data = wb_data[63:32];
      end
      2'd2: begin
        sel_fm   = wb_fmode[2];
        sel_reg  = wb_reg[14:10];
        sel_data = wb_data[95:64];
      end
      default: ;
    endcase
  end

  assign issue_x0    = !issue_fmode && (issue_reg == 5'd0);
  assign issue_stall = sb_q[{issue_fmode, issue_reg}] && !issue_x0;
  assign issue_acc   = issue_valid && !issue_stall && !issue_x0;
  assign busy1       = sb_q[{rfmode1, rreg1}];
  assign busy2       = sb_q[{rfmode2, rreg2}];
  assign wb_ready    = rstn ? gnt_oh : 3'b000;

  // Next-state: writeback port load/hold and scoreboard clear-then-set (set wins).
  always_comb begin
    last_grant_d = last_grant_q;
    wenable_d    = 1'b0;
    wfmode_d     = wfmode_q;
    wreg_d       = wreg_q;
    wdata_d      = wdata_q;
    sb_d         = sb_q;
    if (hs) begin
      last_grant_d = gnt_idx;
      wenable_d    = sel_fm || (sel_reg != 5'd0);
      wfmode_d     = sel_fm;
      wreg_d       = sel_reg;
      wdata_d      = sel_data;
    end
    if (wenable_q) begin
      sb_d[{wfmode_q, wreg_q}] = 1'b0;
    end
    if (issue_acc) begin
      sb_d[{issue_fmode, issue_reg}] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_grant_q <= LAST_RST;
      wenable_q    <= 1'b0;
      wfmode_q     <= 1'b0;
      wreg_q       <= '0;
      wdata_q      <= '0;
      sb_q         <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      wenable_q    <= wenable_d;
      wfmode_q     <= wfmode_d;
      wreg_q       <= wreg_d;
      wdata_q      <= wdata_d;
      sb_q         <= sb_d;
    end
  end

  assign wenable = wenable_q;
  assign wfmode  = wfmode_q;
  assign wreg    = wreg_q;
  assign wdata   = wdata_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, corner-case sequences,
// then random traffic checked against a behavioural model.
module tb_regfile_wb_arbiter;

  localparam int unsigned PRIO = 0;

  logic        clk = 1'b0;
  logic        rstn;
  logic [2:0]  wb_valid, wb_ready, wb_fmode;
  logic [14:0] wb_reg;
  logic [95:0] wb_data;
  logic        wenable, wfmode;
  logic [4:0]  wreg;
  logic [31:0] wdata;
  logic        issue_valid, issue_fmode, issue_stall;
  logic [4:0]  issue_reg;
  logic        rfmode1, rfmode2, busy1, busy2;
  logic [4:0]  rreg1, rreg2;

  regfile_wb_arbiter #(.PRIO_RESET(PRIO)) dut (
    .clk(clk), .rstn(rstn),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_fmode(wb_fmode),
    .wb_reg(wb_reg), .wb_data(wb_data),
    .wenable(wenable), .wfmode(wfmode), .wreg(wreg), .wdata(wdata),
    .issue_valid(issue_valid), .issue_fmode(issue_fmode), .issue_reg(issue_reg),
    .issue_stall(issue_stall),
    .rfmode1(rfmode1), .rfmode2(rfmode2), .rreg1(rreg1), .rreg2(rreg2),
    .busy1(busy1), .busy2(busy2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int          m_last;
  bit          m_busy[64];
  bit          m_we, m_fm;
  logic [4:0]  m_reg;
  logic [31:0] m_data;

  typedef struct {
    logic [2:0]  valid;
    logic [2:0]  fm;
    logic [14:0] regs;
    logic [95:0] data;
    logic [2:0]  e_ready;
    logic        e_we;
    bit          chk_pay;
    logic        e_fm;
    logic [4:0]  e_reg;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sb_idx(input bit fm, input logic [4:0] r);
    return (fm ? 32 : 0) + int'(r);
  endfunction

  function automatic int exp_grant();
    for (int k = 1; k <= 3; k++) begin
      int i;
      i = (m_last + k) % 3;
      if (wb_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_last = (PRIO + 2) % 3;
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_we = 1'b0; m_fm = 1'b0; m_reg = '0; m_data = '0;
  endtask

  task automatic model_step();
    int g;
    bit acc;
    g   = exp_grant();
    acc = issue_valid && !m_busy[sb_idx(issue_fmode, issue_reg)]
          && !(!issue_fmode && issue_reg == 5'd0);
    if (m_we) m_busy[sb_idx(m_fm, m_reg)] = 1'b0;
    if (acc) m_busy[sb_idx(issue_fmode, issue_reg)] = 1'b1;
    if (g >= 0) begin
      m_last = g;
      m_fm   = wb_fmode[g];
      m_reg  = wb_reg[g*5 +: 5];
      m_data = wb_data[g*32 +: 32];
      m_we   = m_fm || (m_reg != 5'd0);
    end else begin
      m_we = 1'b0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_comb();
    int g;
    logic [2:0] er;
    g  = exp_grant();
    er = (g >= 0) ? 3'(1 << g) : 3'b000;
    check("wb_ready", 32'(wb_ready), 32'(er));
    check("issue_stall", 32'(issue_stall),
          32'(m_busy[sb_idx(issue_fmode, issue_reg)]));
    check("busy1", 32'(busy1), 32'(m_busy[sb_idx(rfmode1, rreg1)]));
    check("busy2", 32'(busy2), 32'(m_busy[sb_idx(rfmode2, rreg2)]));
  endtask

  task automatic check_regs();
    check("wenable", 32'(wenable), 32'(m_we));
    if (m_we) begin
      check("wfmode", 32'(wfmode), 32'(m_fm));
      check("wreg", 32'(wreg), 32'(m_reg));
      check("wdata", wdata, m_data);
    end
  endtask

  initial begin
    logic [2:0]  pfm;
    logic [14:0] preg;
    logic [95:0] pdata;
    int          g;

    pfm   = 3'b010;
    preg  = {5'd7, 5'd3, 5'd5};
    pdata = {32'hBBBB0002, 32'hAAAA0001, 32'h12345678};
    tbl[0] = '{3'b111, pfm, preg, pdata, 3'b001, 1'b1, 1'b1, 1'b0, 5'd5, 32'h12345678};
    tbl[1] = '{3'b111, pfm, preg, pdata, 3'b010, 1'b1, 1'b1, 1'b1, 5'd3, 32'hAAAA0001};
    tbl[2] = '{3'b111, pfm, preg, pdata, 3'b100, 1'b1, 1'b1, 1'b0, 5'd7, 32'hBBBB0002};
    tbl[3] = '{3'b111, pfm, preg, pdata, 3'b001, 1'b1, 1'b1, 1'b0, 5'd5, 32'h12345678};
    tbl[4] = '{3'b000, pfm, preg, pdata, 3'b000, 1'b0, 1'b1, 1'b0, 5'd5, 32'h12345678};
    tbl[5] = '{3'b001, pfm, preg, pdata, 3'b001, 1'b1, 1'b1, 1'b0, 5'd5, 32'h12345678};
    tbl[6] = '{3'b000, pfm, preg, pdata, 3'b000, 1'b0, 1'b1, 1'b0, 5'd5, 32'h12345678};
    tbl[7] = '{3'b100, pfm, {5'd0, 5'd3, 5'd5}, pdata, 3'b100, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0};

    // Reset state, with requests and a claim present
    rstn = 1'b0;
    wb_valid = 3'b111; wb_fmode = pfm; wb_reg = preg; wb_data = pdata;
    issue_valid = 1'b1; issue_fmode = 1'b1; issue_reg = 5'd3;
    rfmode1 = 1'b1; rreg1 = 5'd3; rfmode2 = 1'b0; rreg2 = 5'd5;
    model_reset();
    #1;
    check("rst_wb_ready", 32'(wb_ready), 32'd0);
    check("rst_wenable", 32'(wenable), 32'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_issue_stall", 32'(issue_stall), 32'd0);
    check("rst_busy1", 32'(busy1), 32'd0);
    issue_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn = 1'b1;

    // Directed vector table: round-robin from reset, single ALU write, x0 write
    for (int r = 0; r < 8; r++) begin
      wb_valid = tbl[r].valid; wb_fmode = tbl[r].fm;
      wb_reg = tbl[r].regs; wb_data = tbl[r].data;
      #1;
      check($sformatf("tbl%0d_ready", r), 32'(wb_ready), 32'(tbl[r].e_ready));
      tick();
      check($sformatf("tbl%0d_wenable", r), 32'(wenable), 32'(tbl[r].e_we));
      if (tbl[r].chk_pay) begin
        check($sformatf("tbl%0d_wfmode", r), 32'(wfmode), 32'(tbl[r].e_fm));
        check($sformatf("tbl%0d_wreg", r), 32'(wreg), 32'(tbl[r].e_reg));
        check($sformatf("tbl%0d_wdata", r), wdata, tbl[r].e_data);
      end
    end
    wb_valid = 3'b000;

    // Integer x0 claim never stalls and never becomes busy
    issue_valid = 1'b1; issue_fmode = 1'b0; issue_reg = 5'd0;
    #1;
    check("x0_stall_a", 32'(issue_stall), 32'd0);
    tick();
    check("x0_stall_b", 32'(issue_stall), 32'd0);
    issue_valid = 1'b0;

    // Claim f3, then FPU writes f3; busy clears only after the write cycle
    rfmode1 = 1'b1; rreg1 = 5'd3;
    issue_valid = 1'b1; issue_fmode = 1'b1; issue_reg = 5'd3;
    #1;
    check("f3_stall_free", 32'(issue_stall), 32'd0);
    tick();
    issue_valid = 1'b0;
    #1;
    check("f3_busy_set", 32'(busy1), 32'd1);
    check("f3_stall_busy", 32'(issue_stall), 32'd1);
    wb_valid = 3'b010; wb_fmode = 3'b010; wb_reg = {5'd7, 5'd3, 5'd5};
    wb_data = {32'h0, 32'hF3F3F3F3, 32'h0};
    #1;
    check("f3_ready", 32'(wb_ready), 32'b010);
    tick();
    wb_valid = 3'b000;
    #1;
    check("f3_wenable", 32'(wenable), 32'd1);
    check("f3_wreg", 32'(wreg), 32'd3);
    check("f3_wfmode", 32'(wfmode), 32'd1);
    check("f3_busy_in_write", 32'(busy1), 32'd1);
    tick();
    check("f3_busy_cleared", 32'(busy1), 32'd0);
    check("f3_wenable_off", 32'(wenable), 32'd0);

    // Unclaimed f3 write, then claim f3 in the write cycle: set wins
    wb_valid = 3'b010;
    #1;
    tick();
    wb_valid = 3'b000;
    issue_valid = 1'b1;
    #1;
    check("setwin_wenable", 32'(wenable), 32'd1);
    check("setwin_stall", 32'(issue_stall), 32'd0);
    tick();
    issue_valid = 1'b0;
    #1;
    check("setwin_busy", 32'(busy1), 32'd1);

    // Async reset with busy bits set and a write in flight
    wb_valid = 3'b001; wb_fmode = 3'b000; wb_reg = {5'd0, 5'd0, 5'd9};
    wb_data = {64'h0, 32'hCAFEF00D};
    #1;
    tick();
    wb_valid = 3'b111;
    issue_valid = 1'b1;
    check("pre_rst_wenable", 32'(wenable), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    model_reset();
    check("arst_wenable", 32'(wenable), 32'd0);
    check("arst_wfmode", 32'(wfmode), 32'd0);
    check("arst_wreg", 32'(wreg), 32'd0);
    check("arst_wdata", wdata, 32'd0);
    check("arst_busy1", 32'(busy1), 32'd0);
    check("arst_ready", 32'(wb_ready), 32'd0);
    check("arst_stall", 32'(issue_stall), 32'd0);
    @(posedge clk); #1;
    wb_valid = 3'b000; issue_valid = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    #1;
    check("post_rst_busy1", 32'(busy1), 32'd0);
    tick();
    check("post_rst_wenable", 32'(wenable), 32'd0);

    // Random traffic against the model; requesters hold payload until granted
    g = -1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < 3; i++) begin
        if (!wb_valid[i] || g == i) begin
          wb_valid[i]         = 1'($urandom_range(0, 1));
          wb_fmode[i]         = 1'($urandom_range(0, 1));
          wb_reg[i*5 +: 5]    = 5'($urandom_range(0, 7));
          wb_data[i*32 +: 32] = $urandom;
        end
      end
      issue_valid = 1'($urandom_range(0, 1));
      issue_fmode = 1'($urandom_range(0, 1));
      issue_reg   = 5'($urandom_range(0, 7));
      rfmode1 = 1'($urandom_range(0, 1)); rreg1 = 5'($urandom_range(0, 7));
      rfmode2 = 1'($urandom_range(0, 1)); rreg2 = 5'($urandom_range(0, 7));
      #1;
      check_comb();
      g = exp_grant();
      tick();
      check_regs();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
